mastermind_board: RTL

- Parametrised guess-board and scoring engine for the Mastermind game.
- Stores every guess row, edits the active row under a peg cursor, and scores a submitted row against a latched secret using a multi-cycle exact/partial FSM.
- Reports win/lose and exposes a registered row read port for the VGA renderer.
- Replaces the fixed 6x4x3-bit matrix handling in the top level.

---
 rtl/mastermind_board.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mastermind_board.sv
// mastermind_board
//   Guess board and scoring engine for Mastermind. Holds every guess row,
//   lets the player edit the active row under a peg cursor, and scores a
//   submitted row against a latched secret in a multi-cycle exact/colour
//   pass. Win and lose are sticky until reset.
//
// Ports
//   Clk, Reset          clock, synchronous active-low reset
//   secret              answer, peg i at [i*COLOR_W +: COLOR_W]
//   color_in, wr_en     write colour at the cursor of the active row
//   cur_left/cur_right  move the cursor with wrap (both together: no move)
//   submit              score the active row (refused if any peg is empty)
//   rd_row              registered read select for the renderer
//   rd_data/rd_black/rd_white  pegs and feedback of rd_row, one cycle later
//   cursor, row         active peg and active row
//   busy                scoring in progress
//   reject              one-cycle pulse on a refused submit
//   score_valid         one-cycle pulse when feedback is written
//   win, lose           game outcome, held until reset
module mastermind_board #(
    parameter  int PEGS      = 4,
    parameter  int COLOR_W   = 3,
    parameter  int MAX_GUESS = 6,
    localparam int RW        = $clog2(MAX_GUESS),
    localparam int PW        = $clog2(PEGS),
    localparam int SW        = $clog2(PEGS + 1)
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [PEGS*COLOR_W-1:0] secret,
    input  logic [COLOR_W-1:0]      color_in,
    input  logic                    wr_en,
    input  logic                    cur_left,
    input  logic                    cur_right,
    input  logic                    submit,
    input  logic [RW-1:0]           rd_row,
    output logic [PEGS*COLOR_W-1:0] rd_data,
    output logic [SW-1:0]           rd_black,
    output logic [SW-1:0]           rd_white,
    output logic [PW-1:0]           cursor,
    output logic [RW-1:0]           row,
    output logic                    busy,
    output logic                    reject,
    output logic                    score_valid,
    output logic                    win,
    output logic                    lose
);

    localparam int NCOL  = (1 << COLOR_W) - 1;
    localparam int ROW_W = PEGS * COLOR_W;

    typedef enum logic [2:0] {
        S_INPUT, S_SCORE_X, S_SCORE_C, S_WB, S_WIN, S_LOSE
    } state_t;

    function automatic logic [COLOR_W-1:0] peg_at(input logic [ROW_W-1:0] v, input int idx);
        return v[idx*COLOR_W +: COLOR_W];
    endfunction

    function automatic logic row_full(input logic [ROW_W-1:0] v);
        logic full;
        full = 1'b1;
        for (int i = 0; i < PEGS; i++)
            if (v[i*COLOR_W +: COLOR_W] == '0) full = 1'b0;
        return full;
    endfunction

    function automatic logic [SW-1:0] count_color(input logic [ROW_W-1:0] v,
                                                  input logic [COLOR_W-1:0] c);
        logic [SW-1:0] n;
        n = '0;
        for (int i = 0; i < PEGS; i++)
            if (v[i*COLOR_W +: COLOR_W] == c) n = n + SW'(1);
        return n;
    endfunction

    function automatic logic [SW-1:0] min_sw(input logic [SW-1:0] a, input logic [SW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t                         state_q, state_d;
    logic [MAX_GUESS-1:0][ROW_W-1:0] board_q, board_d;
    logic [MAX_GUESS-1:0][SW-1:0]    fb_black_q, fb_black_d;
    logic [MAX_GUESS-1:0][SW-1:0]    fb_white_q, fb_white_d;
    logic [ROW_W-1:0]               guess_q, guess_d;
    logic [ROW_W-1:0]               secret_q, secret_d;
    logic [SW-1:0]                  black_q, black_d;
    logic [SW-1:0]                  total_q, total_d;
    logic [PW-1:0]                  k_q, k_d;
    logic [COLOR_W-1:0]             c_q, c_d;
    logic [PW-1:0]                  cursor_q, cursor_d;
    logic [RW-1:0]                  row_q, row_d;
    logic                           busy_q, busy_d;
    logic                           reject_q, reject_d;
    logic                           score_valid_q, score_valid_d;
    logic                           win_q, win_d;
    logic                           lose_q, lose_d;
    logic [ROW_W-1:0]               rd_data_q, rd_data_d;
    logic [SW-1:0]                  rd_black_q, rd_black_d;
    logic [SW-1:0]                  rd_white_q, rd_white_d;

    always_comb begin
        state_d       = state_q;
        board_d       = board_q;
        fb_black_d    = fb_black_q;
        fb_white_d    = fb_white_q;
        guess_d       = guess_q;
        secret_d      = secret_q;
        black_d       = black_q;
        total_d       = total_q;
        k_d           = k_q;
        c_d           = c_q;
        cursor_d      = cursor_q;
        row_d         = row_q;
        reject_d      = 1'b0;
        score_valid_d = 1'b0;
        win_d         = win_q;
        lose_d        = lose_q;

        case (state_q)
            S_INPUT: begin
                // A submit takes priority: any coincident edit is dropped so
                // the scored row is exactly what the player saw.
                if (submit) begin
                    if (!row_full(board_q[row_q])) begin
                        reject_d = 1'b1;
                    end else begin
                        guess_d  = board_q[row_q];
                        secret_d = secret;
                        black_d  = '0;
                        total_d  = '0;
                        k_d      = '0;
                        state_d  = S_SCORE_X;
                    end
                end else begin
                    if (wr_en)
                        board_d[row_q][int'(cursor_q)*COLOR_W +: COLOR_W] = color_in;
                    if (cur_right && !cur_left)
                        cursor_d = (cursor_q == PW'(PEGS - 1)) ? '0 : cursor_q + PW'(1);
                    else if (cur_left && !cur_right)
                        cursor_d = (cursor_q == '0) ? PW'(PEGS - 1) : cursor_q - PW'(1);
                end
            end
            S_SCORE_X: begin
                if (peg_at(guess_q, int'(k_q)) == peg_at(secret_q, int'(k_q)))
                    black_d = black_q + SW'(1);
                if (k_q == PW'(PEGS - 1)) begin
                    c_d     = COLOR_W'(1);
                    state_d = S_SCORE_C;
                end else begin
                    k_d = k_q + PW'(1);
                end
            end
            S_SCORE_C: begin
                // Sum of per-colour minima counts every colour match,
                // exact ones included; white falls out as total - black.
                total_d = total_q + min_sw(count_color(guess_q, c_q), count_color(secret_q, c_q));
                if (c_q == COLOR_W'(NCOL))
                    state_d = S_WB;
                else
                    c_d = c_q + COLOR_W'(1);
            end
            S_WB: begin
                fb_black_d[row_q] = black_q;
                fb_white_d[row_q] = total_q - black_q;
                score_valid_d     = 1'b1;
                if (black_q == SW'(PEGS)) begin
                    win_d   = 1'b1;
                    state_d = S_WIN;
                end else if (row_q == RW'(MAX_GUESS - 1)) begin
                    lose_d  = 1'b1;
                    state_d = S_LOSE;
                end else begin
                    row_d    = row_q + RW'(1);
                    cursor_d = '0;
                    state_d  = S_INPUT;
                end
            end
            default: ;  // WIN / LOSE hold until reset
        endcase

        busy_d = (state_d == S_SCORE_X) || (state_d == S_SCORE_C) || (state_d == S_WB);

        rd_data_d  = '0;
        rd_black_d = '0;
        rd_white_d = '0;
        if (int'(rd_row) < MAX_GUESS) begin
            rd_data_d  = board_q[rd_row];
            rd_black_d = fb_black_q[rd_row];
            rd_white_d = fb_white_q[rd_row];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q       <= S_INPUT;
            board_q       <= '0;
            fb_black_q    <= '0;
            fb_white_q    <= '0;
            black_q       <= '0;
            total_q       <= '0;
            k_q           <= '0;
            c_q           <= '0;
            cursor_q      <= '0;
            row_q         <= '0;
            busy_q        <= 1'b0;
            reject_q      <= 1'b0;
            score_valid_q <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            rd_data_q     <= '0;
            rd_black_q    <= '0;
            rd_white_q    <= '0;
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            fb_black_q    <= fb_black_d;
            fb_white_q    <= fb_white_d;
            black_q       <= black_d;
            total_q       <= total_d;
            k_q           <= k_d;
            c_q           <= c_d;
            cursor_q      <= cursor_d;
            row_q         <= row_d;
            busy_q        <= busy_d;
            reject_q      <= reject_d;
            score_valid_q <= score_valid_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
            rd_data_q     <= rd_data_d;
            rd_black_q    <= rd_black_d;
            rd_white_q    <= rd_white_d;
        end
    end

    // Latched operands are pure data and are always loaded before use.
    always_ff @(posedge Clk) begin
        guess_q  <= guess_d;
        secret_q <= secret_d;
    end

    assign rd_data     = rd_data_q;
    assign rd_black    = rd_black_q;
    assign rd_white    = rd_white_q;
    assign cursor      = cursor_q;
    assign row         = row_q;
    assign busy        = busy_q;
    assign reject      = reject_q;
    assign score_valid = score_valid_q;
    assign win         = win_q;
    assign lose        = lose_q;

endmodule
